e_muldiv: RTL and testbench
===========================

# e_muldiv

Multi-cycle multiply/divide unit with HI/LO registers, sitting in the execute stage directly downstream of the ID/EX pipeline register. Consumes the forwarded rs/rt operands and a decoded md-operation code from that register. Produces a busy indication for the hazard/stall unit, and the HI/LO read value that is muxed into the EX-stage result.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10: busy cycles for div/divu (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, asserted when 0
- E_mdop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none
- E_rs  input  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source)
- E_rt  input  32  forwarded rt value (divisor / multiplier)
- E_start  output  1  combinational: E_mdop is 1–4
- E_busy  output  1  combinational: E_start OR internal busy
- E_mdout  output  32  combinational: HI when E_mdop=7, LO when E_mdop=8, else 0
- E_hi, E_lo  output  32 each  current architectural HI/LO (debug/trace)

## Operation
- State: IDLE, RUN. Internal regs: HI, LO, pend_hi, pend_lo, cnt (4 bits min, sized to max parameter), busy.
- IDLE with op 1–4 at a rising edge:
  - Compute the result combinationally from E_rs/E_rt and latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Set busy and go to RUN.
- Results:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: HI/LO keep their old values on commit (pend = current HI/LO), unless the configuration feature below is compiled in.
- RUN: cnt decrements each edge. On the edge where cnt==1:
  - HI/LO ← pend.
  - busy clears and the state returns to IDLE.
- mthi/mtlo in IDLE: HI (resp. LO) ← E_rs at the edge.
- mthi/mtlo in RUN: ignored. The stall unit guarantees this never happens.
- op 1–4 while RUN: ignored (no restart, no queuing).
- mfhi/mflo: pure combinational read of the current HI/LO. It does not see pending results.
- Reset (any time, including mid-RUN): HI=LO=pend=0, cnt=0, busy=0, state IDLE; the in-flight operation is discarded.
- A flushed ID/EX register presents op 0, so no start occurs.

## Timing
- Reset values: E_busy=0, E_start=0, E_mdout=0, E_hi=0, E_lo=0.
- Start in cycle T, where op 1–4 is visible:
  - E_busy is high from T through T+N, with N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO are updated at the edge ending cycle T+N.
  - mfhi/mflo in cycle T+N+1 returns the new value.
- Back-to-back: a new start is accepted in cycle T+N+1.
- mthi/mtlo latency: written at the edge ending the cycle in which the op is presented; visible the next cycle.
- The hazard unit must stall ID whenever E_busy=1 and the ID instruction is any md op.

## Configuration
- MD_DIVZERO_EN defined:
  - div/divu with divisor 0 skips the counter (N=1 regardless of DIV_CYCLES).
  - Commits LO=0xFFFFFFFF and HI=dividend.
- MD_DIVZERO_EN undefined:
  - Divisor 0 takes the full DIV_CYCLES.
  - HI/LO are left unchanged.

## Test plan
- Reset mid-operation: reset low at cycle 3 of a div → E_busy=0, E_hi=E_lo=0 asynchronously. After release, mflo returns 0.
- mult with rs=0xFFFFFFFE (-2), rt=3 → E_busy high 6 cycles (T..T+5). Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div with rs=0xFFFFFFF9 (-7), rt=2 → after 11 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- mtlo 0x1234, then mflo next cycle → E_mdout=0x1234. mthi presented during RUN → HI unchanged after commit.
- Divide by zero: without MD_DIVZERO_EN, HI/LO remain 0xAAAA/0x5555 after 11 busy cycles. With it, E_busy is high 2 cycles, then LO=0xFFFFFFFF and HI=dividend.
- Start during RUN: a second mult presented at T+2 is ignored, and only the first result commits at T+5.

Source files
------------

// File: rtl/e_muldiv.sv
// ---------------------------------------------------------------------------
// e_muldiv
//
// Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits
// in the execute stage right after the ID/EX pipeline register. It computes
// the mult/multu/div/divu result as soon as the op is accepted and parks it in
// pending registers. A down-counter then holds the unit busy, so the result
// commits to HI/LO after the configured latency.
//
// Parameters:
//   MULT_CYCLES  busy cycles after the start cycle for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles after the start cycle for div/divu   (>= 1)
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous reset, active low
//   E_mdop   in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                     6 mtlo, 7 mfhi, 8 mflo, 9-15 none
//   E_rs     in  32   dividend / multiplicand / mthi-mtlo source
//   E_rt     in  32   divisor / multiplier
//   E_start  out  1   E_mdop is a mult/multu/div/divu (combinational)
//   E_busy   out  1   E_start or an operation in flight (combinational)
//   E_mdout  out 32   HI for mfhi, LO for mflo, otherwise 0 (combinational)
//   E_hi     out 32   current architectural HI
//   E_lo     out 32   current architectural LO
//
// Configuration macro:
//   MD_DIVZERO_EN  when defined, a divide by zero finishes after a single busy
//                  cycle and commits LO = 0xFFFFFFFF, HI = dividend. When it is
//                  undefined, a divide by zero runs the full DIV_CYCLES and
//                  leaves HI/LO unchanged.
// ---------------------------------------------------------------------------
module e_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdop,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  output logic        E_start,
  output logic        E_busy,
  output logic [31:0] E_mdout,
  output logic [31:0] E_hi,
  output logic [31:0] E_lo
);

  // The counter is at least 4 bits wide. It grows if either latency parameter
  // needs more bits.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W_RAW  = $clog2(MAX_CYCLES + 1);
  localparam int CNT_W      = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pendHi;
  logic [31:0]      r_pendLo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [63:0]      w_prodSigned;
  logic [63:0]      w_prodUnsigned;
  logic             w_rtZero;
  logic [31:0]      w_absRs;
  logic [31:0]      w_absRt;
  logic [31:0]      w_magQuot;
  logic [31:0]      w_magRem;
  logic [31:0]      w_sQuot;
  logic [31:0]      w_sRem;
  logic [31:0]      w_uDivisor;
  logic [31:0]      w_uQuot;
  logic [31:0]      w_uRem;
  logic [31:0]      w_resHi;
  logic [31:0]      w_resLo;
  logic [CNT_W-1:0] w_cycles;

  // Both products are taken on 64-bit operands. For the signed product the
  // operands are sign-extended, so the low 64 bits equal the two's-complement
  // product.
  always_comb begin
    w_prodSigned   = {{32{E_rs[31]}}, E_rs} * {{32{E_rt[31]}}, E_rt};
    w_prodUnsigned = {32'd0, E_rs} * {32'd0, E_rt};
  end

  // Signed division runs on magnitudes, and the signs are applied afterwards:
  // the quotient is negated when the operand signs differ, and the remainder
  // follows the dividend. The zero divisor is replaced by 1 so the dividers
  // never see it; the zero-divisor result is chosen separately below. With
  // this approach 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
  always_comb begin
    w_rtZero   = (E_rt == 32'd0);
    w_absRs    = E_rs[31] ? (~E_rs + 32'd1) : E_rs;
    w_absRt    = w_rtZero ? 32'd1 : (E_rt[31] ? (~E_rt + 32'd1) : E_rt);
    w_magQuot  = w_absRs / w_absRt;
    w_magRem   = w_absRs % w_absRt;
    w_sQuot    = (E_rs[31] ^ E_rt[31]) ? (~w_magQuot + 32'd1) : w_magQuot;
    w_sRem     = E_rs[31] ? (~w_magRem + 32'd1) : w_magRem;
    w_uDivisor = w_rtZero ? 32'd1 : E_rt;
    w_uQuot    = E_rs / w_uDivisor;
    w_uRem     = E_rs % w_uDivisor;
  end

  // Select the value to park in the pending registers and the busy length.
  // For a zero divisor the choice depends on MD_DIVZERO_EN.
  always_comb begin
    w_resHi  = r_hi;
    w_resLo  = r_lo;
    w_cycles = MULT_N;
    case (E_mdop)
      OP_MULT: begin
        w_resHi  = w_prodSigned[63:32];
        w_resLo  = w_prodSigned[31:0];
        w_cycles = MULT_N;
      end
      OP_MULTU: begin
        w_resHi  = w_prodUnsigned[63:32];
        w_resLo  = w_prodUnsigned[31:0];
        w_cycles = MULT_N;
      end
      OP_DIV, OP_DIVU: begin
        w_cycles = DIV_N;
        if (w_rtZero) begin
`ifdef MD_DIVZERO_EN
          w_resHi  = E_rs;
          w_resLo  = 32'hFFFF_FFFF;
          w_cycles = CNT_1;
`else
          w_resHi  = r_hi;
          w_resLo  = r_lo;
`endif
        end else if (E_mdop == OP_DIV) begin
          w_resHi = w_sRem;
          w_resLo = w_sQuot;
        end else begin
          w_resHi = w_uRem;
          w_resLo = w_uQuot;
        end
      end
      default: begin
        w_resHi  = r_hi;
        w_resLo  = r_lo;
        w_cycles = MULT_N;
      end
    endcase
  end

  // Control FSM and architectural state. In IDLE, a start latches the result
  // and the cycle count, and mthi/mtlo write directly. In RUN, every op is
  // ignored; the result commits and the FSM drops back to IDLE on the edge
  // where the counter reads 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_pendHi <= 32'd0;
      r_pendLo <= 32'd0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (E_start) begin
            r_pendHi <= w_resHi;
            r_pendLo <= w_resLo;
            r_cnt    <= w_cycles;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end else if (E_mdop == OP_MTHI) begin
            r_hi <= E_rs;
          end else if (E_mdop == OP_MTLO) begin
            r_lo <= E_rs;
          end
        end
        ST_RUN: begin
          if (r_cnt == CNT_1) begin
            r_hi    <= r_pendHi;
            r_lo    <= r_pendLo;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // The hazard unit needs busy in the start cycle too. E_start covers that
  // cycle, before the internal busy flag is set.
  always_comb begin
    E_start = (E_mdop >= OP_MULT) && (E_mdop <= OP_DIVU);
    E_busy  = E_start || r_busy;
  end

  // mfhi/mflo read the architectural registers only, never the pending result.
  always_comb begin
    E_mdout = 32'd0;
    if (E_mdop == OP_MFHI) begin
      E_mdout = r_hi;
    end else if (E_mdop == OP_MFLO) begin
      E_mdout = r_lo;
    end
  end

  assign E_hi = r_hi;
  assign E_lo = r_lo;

endmodule

// File: tb/tb_e_muldiv.sv
// ---------------------------------------------------------------------------
// tb_e_muldiv
//
// Directed bench for e_muldiv. A transaction-level model tracks HI/LO, the
// pending result and the remaining busy cycles using plain integer
// arithmetic. A compare process checks every DUT output against this model
// at each falling clock edge. Hand-computed literal expectations pin the
// results of the key operations.
// ---------------------------------------------------------------------------
module tb_e_muldiv;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  mdOp;
  logic [31:0] rsVal;
  logic [31:0] rtVal;
  logic        eStart;
  logic        eBusy;
  logic [31:0] eMdout;
  logic [31:0] eHi;
  logic [31:0] eLo;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state: architectural HI/LO, pending result, busy cycles remaining.
  logic [31:0] mHi     = 32'd0;
  logic [31:0] mLo     = 32'd0;
  logic [31:0] mPendHi = 32'd0;
  logic [31:0] mPendLo = 32'd0;
  int          mLeft   = 0;

  e_muldiv #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .E_mdop (mdOp),
    .E_rs   (rsVal),
    .E_rt   (rtVal),
    .E_start(eStart),
    .E_busy (eBusy),
    .E_mdout(eMdout),
    .E_hi   (eHi),
    .E_lo   (eLo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs,
                               input logic [31:0] rt);
    mdOp  = op;
    rsVal = rs;
    rtVal = rt;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model. On reset it clears everything. On a clock edge it
  // applies the op that was visible during the cycle just ending.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mHi = 0; mLo = 0; mPendHi = 0; mPendLo = 0; mLeft = 0;
      end else if (mLeft > 0) begin
        mLeft = mLeft - 1;
        if (mLeft == 0) begin
          mHi = mPendHi;
          mLo = mPendLo;
        end
      end else begin
        case (mdOp)
          4'd1: begin
            longint p;
            p = longint'($signed(rsVal)) * longint'($signed(rtVal));
            mPendHi = p[63:32]; mPendLo = p[31:0]; mLeft = MULT_N;
          end
          4'd2: begin
            logic [63:0] p;
            p = {32'd0, rsVal} * {32'd0, rtVal};
            mPendHi = p[63:32]; mPendLo = p[31:0]; mLeft = MULT_N;
          end
          4'd3, 4'd4: begin
            mLeft = DIV_N;
            if (rtVal == 0) begin
`ifdef MD_DIVZERO_EN
              mPendHi = rsVal; mPendLo = 32'hFFFFFFFF; mLeft = 1;
`else
              mPendHi = mHi; mPendLo = mLo;
`endif
            end else if (mdOp == 4'd4) begin
              mPendLo = rsVal / rtVal;
              mPendHi = rsVal % rtVal;
            end else if (rsVal == 32'h80000000 && rtVal == 32'hFFFFFFFF) begin
              mPendLo = 32'h80000000; mPendHi = 32'd0;
            end else begin
              int a, b, q, r;
              a = rsVal; b = rtVal;
              q = a / b; r = a % b;
              mPendLo = q; mPendHi = r;
            end
          end
          4'd5: mHi = rsVal;
          4'd6: mLo = rsVal;
          default: ;
        endcase
      end
    end
  end

  // Compare process: mid-cycle check of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic expStart;
        logic [31:0] expOut;
        expStart = (mdOp >= 4'd1) && (mdOp <= 4'd4);
        expOut   = (mdOp == 4'd7) ? mHi : ((mdOp == 4'd8) ? mLo : 32'd0);
        checkOutput("start", {31'd0, eStart}, {31'd0, expStart});
        checkOutput("busy", {31'd0, eBusy}, {31'd0, expStart || (mLeft > 0)});
        checkOutput("mdout", eMdout, expOut);
        checkOutput("hi", eHi, mHi);
        checkOutput("lo", eLo, mLo);
      end
    end
  end

  // Present an op for one cycle, optionally inject a second op in cycle T+2,
  // then wait (bounded) until busy drops. Returns the busy-cycle count and
  // leaves the caller at posedge+1 of the cycle after busy fell.
  task automatic runOp(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [3:0] injOp, input logic [31:0] injRs,
                       input logic [31:0] injRt, output int busyCycles);
    bit done;
    done = 0;
    busyCycles = 0;
    applyStimulus(op, rs, rt);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!eBusy) begin
        done = 1;
        break;
      end
      busyCycles++;
      nextCycle();
      if (i == 1) applyStimulus(injOp, injRs, injRt);
      else applyStimulus(4'd0, 32'd0, 32'd0);
    end
    if (!done) checkOutput("busyTimeout", 32'd1, 32'd0);
    nextCycle();
  endtask

  task automatic readReg(input logic [3:0] op, input string name, input logic [31:0] expected);
    applyStimulus(op, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput(name, eMdout, expected);
    nextCycle();
    applyStimulus(4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    applyStimulus(4'd0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("resetBusy", {31'd0, eBusy}, 32'd0);
    checkOutput("resetHi", eHi, 32'd0);
    checkOutput("resetLo", eLo, 32'd0);
    nextCycle();
    reset = 1'b1;
    nextCycle();

    // mult / multu on -2 * 3
    runOp(4'd1, 32'hFFFFFFFE, 32'd3, 4'd0, 32'd0, 32'd0, n);
    checkOutput("multBusyCycles", 32'(n), 32'd6);
    checkOutput("multHi", eHi, 32'hFFFFFFFF);
    checkOutput("multLo", eLo, 32'hFFFFFFFA);
    readReg(4'd7, "mfhiAfterMult", 32'hFFFFFFFF);
    runOp(4'd2, 32'hFFFFFFFE, 32'd3, 4'd0, 32'd0, 32'd0, n);
    checkOutput("multuHi", eHi, 32'h00000002);
    checkOutput("multuLo", eLo, 32'hFFFFFFFA);

    // div / divu
    runOp(4'd3, 32'hFFFFFFF9, 32'd2, 4'd0, 32'd0, 32'd0, n);
    checkOutput("divBusyCycles", 32'(n), 32'd11);
    checkOutput("divLo", eLo, 32'hFFFFFFFD);
    checkOutput("divHi", eHi, 32'hFFFFFFFF);
    runOp(4'd4, 32'd7, 32'd2, 4'd0, 32'd0, 32'd0, n);
    checkOutput("divuLo", eLo, 32'd3);
    checkOutput("divuHi", eHi, 32'd1);
    runOp(4'd3, 32'h80000000, 32'hFFFFFFFF, 4'd0, 32'd0, 32'd0, n);
    checkOutput("divOvfLo", eLo, 32'h80000000);
    checkOutput("divOvfHi", eHi, 32'd0);
    runOp(4'd3, 32'd7, 32'hFFFFFFFE, 4'd0, 32'd0, 32'd0, n);
    checkOutput("divNegDivisorLo", eLo, 32'hFFFFFFFD);
    checkOutput("divNegDivisorHi", eHi, 32'd1);

    // mtlo then mflo
    applyStimulus(4'd6, 32'h1234, 32'd0);
    nextCycle();
    readReg(4'd8, "mfloAfterMtlo", 32'h1234);

    // mthi during RUN is ignored
    runOp(4'd1, 32'd3, 32'd4, 4'd5, 32'hDEAD, 32'd0, n);
    checkOutput("mthiInRunHi", eHi, 32'd0);
    checkOutput("mthiInRunLo", eLo, 32'd12);

    // a second mult during RUN is ignored
    runOp(4'd1, 32'd5, 32'd6, 4'd1, 32'd7, 32'd8, n);
    checkOutput("restartBusyCycles", 32'(n), 32'd6);
    checkOutput("restartLo", eLo, 32'd30);

    // divide by zero
    applyStimulus(4'd5, 32'hAAAA, 32'd0);
    nextCycle();
    applyStimulus(4'd6, 32'h5555, 32'd0);
    nextCycle();
    runOp(4'd4, 32'h77, 32'd0, 4'd0, 32'd0, 32'd0, n);
`ifdef MD_DIVZERO_EN
    checkOutput("divzBusyCycles", 32'(n), 32'd2);
    checkOutput("divzLo", eLo, 32'hFFFFFFFF);
    checkOutput("divzHi", eHi, 32'h77);
`else
    checkOutput("divzBusyCycles", 32'(n), 32'd11);
    checkOutput("divzLo", eLo, 32'h5555);
    checkOutput("divzHi", eHi, 32'hAAAA);
`endif
    runOp(4'd3, 32'hFFFFFF00, 32'd0, 4'd0, 32'd0, 32'd0, n);

    // reset in cycle 3 of a div
    applyStimulus(4'd6, 32'h9999, 32'd0);
    nextCycle();
    applyStimulus(4'd3, 32'd100, 32'd7);
    nextCycle();
    applyStimulus(4'd0, 32'd0, 32'd0);
    nextCycle();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midResetBusy", {31'd0, eBusy}, 32'd0);
    checkOutput("midResetHi", eHi, 32'd0);
    checkOutput("midResetLo", eLo, 32'd0);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    readReg(4'd8, "mfloAfterReset", 32'd0);
    runOp(4'd2, 32'h10000, 32'h10000, 4'd0, 32'd0, 32'd0, n);
    checkOutput("multuAfterResetHi", eHi, 32'd1);
    checkOutput("multuAfterResetLo", eLo, 32'd0);

    repeat (2) nextCycle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
